// File: rtl/ahb_top_sys.sv
`default_nettype none
// ==========================================================================
// ahb_top_sys : single-transfer AHB-Lite master, decoder, four register
//               slaves and read mux. Optional macro: AHB_TOP_WAIT_EN
//               (one wait state per slave data phase).     Rev 1.0
// ==========================================================================
module ahb_top_sys #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              enable,
   input  logic [DATA_W-1:0] dina,
   input  logic [ADDR_W-1:0] addr,
   input  logic              wr,
   input  logic [2:0]        sel,
   output logic [DATA_W-1:0] dout
);
   localparam int         NUM_SLV       = 4;
   localparam int         DEPTH         = 1 << DEPTH_LOG2;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [ADDR_W-1:0]  lat_addr;
   logic               lat_wr;
   logic [1:0]         lat_sel;
   logic               start;

   logic [1:0]         htrans;
   logic [ADDR_W-1:0]  haddr;
   logic               hwrite;
   logic [DATA_W-1:0]  hwdata;
   logic [DATA_W-1:0]  hrdata;
   logic               hready;
   logic               hresp;
   logic [NUM_SLV-1:0] hsel;
   logic [NUM_SLV-1:0] slv_ready;
   logic [NUM_SLV-1:0] slv_resp;
   logic [DATA_W-1:0]  slv_rdata [NUM_SLV];
   logic [1:0]         dsel;

   // sel[2] set means "no slave": the request is dropped in IDLE
   assign start = enable && !sel[2];

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         lat_addr <= '0;
         lat_wr   <= 1'b0;
         lat_sel  <= 2'd0;
      end else if (state == ST_IDLE && start) begin
         lat_addr <= addr;
         lat_wr   <= wr;
         lat_sel  <= sel[1:0];
      end
   end

   always_comb begin
      state_nxt = state;
      htrans    = HTRANS_IDLE;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_ADDR;
         end
         ST_ADDR: begin
            htrans    = HTRANS_NONSEQ;
            state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (hready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign haddr  = lat_addr;
   assign hwrite = lat_wr;
   assign hwdata = dina;

   always_comb begin
      hsel = '0;
      if (htrans == HTRANS_NONSEQ) hsel[lat_sel] = 1'b1;
   end

   // Data-phase select follows the address phase, as in a standard AHB mux
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         dsel <= 2'd0;
      end else if (hready) begin
         dsel <= lat_sel;
      end
   end

   assign hrdata = slv_rdata[dsel];
   assign hready = slv_ready[dsel];
   assign hresp  = |slv_resp;

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         dout <= '0;
      end else if (state == ST_DATA && hready && !lat_wr) begin
         dout <= hrdata;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLV; gi++) begin : g_slave
         logic [DATA_W-1:0]     mem [DEPTH];
         logic                  dp_active;
         logic                  dp_write;
         logic [DEPTH_LOG2-1:0] dp_word;
         logic                  ready_out;

         always_ff @(posedge hclk) begin
            if (!hresetn) begin
               dp_active <= 1'b0;
               dp_write  <= 1'b0;
               dp_word   <= '0;
            end else if (hready) begin
               dp_active <= hsel[gi] && htrans[1];
               dp_write  <= hwrite;
               dp_word   <= haddr[DEPTH_LOG2-1:0];
            end
         end

         always_ff @(posedge hclk) begin
            if (!hresetn) begin
               for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else if (dp_active && ready_out && dp_write) begin
               mem[dp_word] <= hwdata;
            end
         end

`ifdef AHB_TOP_WAIT_EN
         logic wait_done;

         // Holds HREADY low for exactly the first data-phase cycle
         always_ff @(posedge hclk) begin
            if (!hresetn) begin
               wait_done <= 1'b0;
            end else if (dp_active && !wait_done) begin
               wait_done <= 1'b1;
            end else begin
               wait_done <= 1'b0;
            end
         end

         assign ready_out = !dp_active || wait_done;
`else
         assign ready_out = 1'b1;
`endif

         assign slv_ready[gi] = ready_out;
         assign slv_rdata[gi] = dp_active ? mem[dp_word] : '0;
         assign slv_resp[gi]  = 1'b0;
      end
   endgenerate

   // Upper address bits alias onto the word index; HRESP is always OKAY
   logic unused_ok;
   assign unused_ok = &{1'b0, hresp, haddr[ADDR_W-1:DEPTH_LOG2]};

endmodule
`default_nettype wire

// File: tb/tb_ahb_top_sys.sv
`default_nettype none
// ==========================================================================
// tb_ahb_top_sys : directed bench with a word-array model of the four slaves.
// ==========================================================================
module tb_ahb_top_sys;
   logic        hclk = 1'b0;
   logic        hresetn;
   logic        enable;
   logic [31:0] dina;
   logic [31:0] addr;
   logic        wr;
   logic [2:0]  sel;
   logic [31:0] dout;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   logic [31:0] mmem [4][16];
   logic [31:0] mdout = 32'h0;

   ahb_top_sys #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(4)) dut (
      .hclk    (hclk),
      .hresetn (hresetn),
      .enable  (enable),
      .dina    (dina),
      .addr    (addr),
      .wr      (wr),
      .sel     (sel),
      .dout    (dout)
   );

   always #5 hclk = ~hclk;

   // Model reset: every word and dout return to zero
   always @(posedge hclk) begin
      if (!hresetn) begin
         mdout = 32'h0;
         for (int s = 0; s < 4; s++)
            for (int w = 0; w < 16; w++) mmem[s][w] = 32'h0;
      end
   end

   always @(negedge hclk) begin
      if (chk_on) begin
         total++;
         if (dout !== mdout) begin
            bad++;
            $display("FAIL dout_cycle t=%0t actual=%h expected=%h", $time, dout, mdout);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // One transfer; request inputs are scrambled after edge T and the real
   // write data only appears during the data cycle.
   task automatic xfer(input logic w, input int s, input logic [31:0] a, input logic [31:0] d);
      @(negedge hclk);
      enable = 1'b1; wr = w; sel = 3'(s); addr = a; dina = 32'h0BAD0000;
      @(posedge hclk);
      @(negedge hclk);
      enable = 1'b0; wr = ~w; sel = 3'b111; addr = ~a; dina = ~d;
      @(posedge hclk);
      @(negedge hclk);
      dina = d;
`ifdef AHB_TOP_WAIT_EN
      @(posedge hclk);
`endif
      @(posedge hclk);
      #1;
      if (w) mmem[s][a % 16] = d;
      else   mdout = mmem[s][a % 16];
   endtask

   initial begin
      hresetn = 1'b0; enable = 1'b0; wr = 1'b0; sel = 3'b000;
      addr = 32'h0; dina = 32'h0;
      repeat (2) @(posedge hclk);
      @(negedge hclk);
      hresetn = 1'b1;
      chk_on  = 1'b1;
      check("reset_dout", dout, 32'h0);

      xfer(1'b0, 0, 32'd0, 32'h0);
      check("reset_read_s0", dout, 32'h0);

      xfer(1'b1, 0, 32'd0, 32'hDEADBEEF);
      check("write_holds_dout", dout, 32'h0);
      xfer(1'b0, 0, 32'd0, 32'h0);
      check("read_s0_a0", dout, 32'hDEADBEEF);

      xfer(1'b1, 1, 32'd0, 32'hDEADC0DE);
      xfer(1'b1, 2, 32'd0, 32'hFEEDFACE);
      xfer(1'b0, 1, 32'd0, 32'h0);
      check("iso_s1", dout, 32'hDEADC0DE);
      xfer(1'b0, 2, 32'd0, 32'h0);
      check("iso_s2", dout, 32'hFEEDFACE);
      xfer(1'b0, 0, 32'd0, 32'h0);
      check("iso_s0", dout, 32'hDEADBEEF);

      xfer(1'b1, 3, 32'd5, 32'hDEADFACE);
      xfer(1'b0, 2, 32'd5, 32'h0);
      check("s2_a5_untouched", dout, 32'h0);
      xfer(1'b0, 3, 32'd5, 32'h0);
      check("late_data_a5", dout, 32'hDEADFACE);
      xfer(1'b0, 3, 32'd21, 32'h0);
      check("alias_a21", dout, 32'hDEADFACE);

      // No-slave select: if it leaked through it would write slave 0 word 0
      @(negedge hclk);
      enable = 1'b1; wr = 1'b1; sel = 3'b100; addr = 32'd0; dina = 32'h0BADBAD0;
      @(posedge hclk);
      @(negedge hclk);
      enable = 1'b0;
      check("nosel_dout_held", dout, 32'hDEADFACE);
      xfer(1'b0, 0, 32'd0, 32'h0);
      check("nosel_no_write", dout, 32'hDEADBEEF);

      for (int k = 0; k < 4; k++)
         xfer(1'b1, k, 32'(k + 8), 32'h11111111 * (k + 1));
      for (int k = 0; k < 4; k++) begin
         xfer(1'b0, k, 32'(k + 8 + 16 * (k + 1)), 32'h0);
         check("loop_alias_read", dout, 32'h11111111 * (k + 1));
      end
      xfer(1'b0, 1, 32'hFFFF_FFF0, 32'h0);
      check("high_alias_s1_a0", dout, 32'hDEADC0DE);

      // Reset during the address phase of a write
      @(negedge hclk);
      enable = 1'b1; wr = 1'b1; sel = 3'b000; addr = 32'd7; dina = 32'h12345678;
      @(posedge hclk);
      @(negedge hclk);
      enable = 1'b0; hresetn = 1'b0;
      @(posedge hclk);
      @(negedge hclk);
      hresetn = 1'b1;
      check("midrst_dout", dout, 32'h0);
      xfer(1'b0, 0, 32'd7, 32'h0);
      check("midrst_not_written", dout, 32'h0);
      xfer(1'b0, 0, 32'd0, 32'h0);
      check("midrst_mem_cleared", dout, 32'h0);

      repeat (3) @(posedge hclk);
      @(negedge hclk);
      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ahb_top_sys.md
Name: ahb_top_sys

Overview:
- Self-contained AHB-Lite subsystem: a single-transfer AHB master, an address/slave decoder, four zero-wait-state register-file slaves and a read-data/response multiplexer.
- A simple user-side command interface (enable/wr/addr/dina/sel) is converted into one AHB NONSEQ transfer to the slave chosen by sel.
- Read data is returned on dout.
- Used as a bus-fabric demonstrator and as an integration block for slave verification.

Parameters:
- DATA_W, 32, data bus width (dina, dout, HWDATA, HRDATA).
- ADDR_W, 32, width of the addr input / HADDR.
- DEPTH_LOG2, 4, log2 of words per slave; each slave holds 2^DEPTH_LOG2 words.

Ports:
- hclk  input  1  system clock; all state updates on rising edge.
- hresetn  input  1  synchronous, active-low reset, sampled on rising hclk.
- enable  input  1  request to start a transfer.
- dina  input  DATA_W  write data for the current transfer.
- addr  input  ADDR_W  word address within the selected slave.
- wr  input  1  1 = write, 0 = read.
- sel  input  3  slave select; 3'b000..3'b011 = slave 0..3; 3'b1xx = no slave.
- dout  output  DATA_W  last read data.

Behaviour:
- Reset (hresetn=0 at a rising edge):
  - Master FSM goes to IDLE; any in-flight transfer is aborted with no write committed.
  - dout=0; all slave storage words cleared to 0; internal HTRANS=IDLE.
- Master FSM states: IDLE, ADDR, DATA.
- IDLE:
  - At edge T with enable=1 and sel[2]=0: latch addr, wr and sel[1:0] into the address-phase registers, go to ADDR.
  - Otherwise stay in IDLE.
  - sel[2]=1 with enable=1 is ignored: no transfer, no state change.
- ADDR (one cycle):
  - HTRANS=NONSEQ, HADDR/HWRITE/HSEL driven from the latched values; decoder asserts exactly one HSELx.
  - Selected slave captures address/control at edge T+1.
  - Go to DATA.
- DATA:
  - HWDATA is taken combinationally from dina during this cycle (data follows address by one cycle, per AHB).
  - At edge T+2 with HREADY=1:
    - Write: mem[sel][word] <= dina.
    - Read: dout <= mem[sel][word].
  - Return to IDLE. A new request is sampled at edge T+3 earliest, so at most one transfer is outstanding.
- Word index = addr[DEPTH_LOG2-1:0]. Upper address bits are ignored, so addresses alias modulo 2^DEPTH_LOG2.
- dout changes only at completion of a read; writes and idle cycles hold dout.
- HRESP is always OKAY; slaves never signal error.
- Changes to enable/addr/wr/sel after edge T do not affect the transfer in flight.
- dina is sampled only at the completing edge.

Optional Feature:
- Macro: AHB_TOP_WAIT_EN.
- Defined: every slave inserts exactly one wait state (HREADY=0 during the first data-phase cycle). Completion, dina sampling, memory write and dout update move to edge T+3. Next request is sampled at T+4 earliest.
- Undefined: zero wait states; timing exactly as in Behaviour.

Test Plan:
- Reset: hold hresetn=0 for 2 edges, then release -> dout=0; a read of slave 0 addr 0 returns 0.
- Write then read, slave 0:
  - Write sel=000, addr=0, dina=32'hDEADBEEF.
  - Read sel=000, addr=0 -> dout=32'hDEADBEEF at edge T+2 of the read.
- Slave isolation:
  - Write 32'hDEADC0DE to slave 1 addr 0 and 32'hFEEDFACE to slave 2 addr 0.
  - Read slave 1 -> 32'hDEADC0DE; slave 2 -> 32'hFEEDFACE; slave 0 addr 0 still 32'hDEADBEEF.
- Late write data and aliasing:
  - Write slave 3 with addr=5, dina presented only in the DATA cycle = 32'hDEADFACE.
  - Read addr=5 -> 32'hDEADFACE; read addr=21 -> 32'hDEADFACE (alias).
- No-slave select: enable=1, sel=3'b100, wr=1 -> FSM stays IDLE, no memory changes, dout unchanged.
- Reset mid-transfer: assert hresetn=0 in the ADDR cycle of a write of 32'h12345678 -> word not written, dout=0, FSM in IDLE.
